// File: rtl/demux_1x2_fifo_pkg.sv
`default_nettype none
// ============================================================
// Package : demux_pkg -- shared types/constants for demux_1x2_fifo
// Rev     : 1.0
// ============================================================
package demux_pkg;

  localparam int WIDTH = 32;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } demux_entry_t;

endpackage
`default_nettype wire

// File: rtl/demux_1x2_fifo_sync_fifo.sv
`default_nettype none
// ============================================================
// Module : sync_fifo -- DEPTH-entry single-clock FIFO, registered head
// Rev    : 1.0
// ============================================================
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = r_mem[r_rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_1x2_fifo.sv
`default_nettype none
// ============================================================
// Module : demux_1x2_fifo -- FIFO-buffered 1-to-2 demux, head routed by sel
// Rev    : 1.0
// ============================================================
module demux_1x2_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count,
  output logic             empty,
  output logic             full
);

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  entry_t     w_din;
  entry_t     w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_valid;
  logic [1:0] w_ready;
  logic [1:0] w_fire;

  assign w_din    = {in_sel, in_data};
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_ready  = {out1_ready, out0_ready};
  assign w_pop    = |w_fire;

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Only the channel named by the head's sel can complete a pop.
  for (genvar g = 0; g < 2; g++) begin : g_out
    localparam logic c_sel = (g == 0) ? SEL_OUT0 : SEL_OUT1;
    logic [CNT_W-1:0] r_cnt;

    assign w_valid[g] = !w_empty && (w_head.sel == c_sel);
    assign w_fire[g]  = w_valid[g] && w_ready[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_fire[g]) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_head.data;
  assign out1_data  = w_head.data;
  assign out0_count = g_out[0].r_cnt;
  assign out1_count = g_out[1].r_cnt;
  assign empty      = w_empty;
  assign full       = w_full;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x2_fifo.sv
`default_nettype none
// ============================================================
// Module : tb_demux_1x2_fifo -- queue-model bench for demux_1x2_fifo
// Rev    : 1.0
// ============================================================
module tb_demux_1x2_fifo;
  import demux_pkg::*;

  localparam int W  = demux_pkg::WIDTH;
  localparam int D  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sel;
  logic [W-1:0]  in_data;
  logic          out0_valid, out0_ready, out1_valid, out1_ready;
  logic [W-1:0]  out0_data, out1_data;
  logic [CW-1:0] out0_count, out1_count;
  logic          empty, full;

  demux_1x2_fifo #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out0_count (out0_count),
    .out1_count (out1_count),
    .empty      (empty),
    .full       (full)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: an ordered queue of pending {sel,data} plus two wrapping tallies.
  demux_entry_t  q[$];
  logic [CW-1:0] m_cnt0, m_cnt1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt0 = '0;
      m_cnt1 = '0;
    end else begin
      bit           do_push, do_pop;
      demux_entry_t e;
      do_push = in_valid && (q.size() < D);
      do_pop  = (q.size() > 0) &&
                ((q[0].sel == SEL_OUT0 && out0_ready) || (q[0].sel == SEL_OUT1 && out1_ready));
      if (do_pop) begin
        if (q[0].sel == SEL_OUT0) m_cnt0++;
        else                      m_cnt1++;
        void'(q.pop_front());
      end
      if (do_push) begin
        e.sel  = in_sel;
        e.data = in_data;
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit h0, h1;
      h0 = (q.size() > 0) && (q[0].sel == SEL_OUT0);
      h1 = (q.size() > 0) && (q[0].sel == SEL_OUT1);
      check("empty",      empty,      q.size() == 0);
      check("full",       full,       q.size() == D);
      check("in_ready",   in_ready,   q.size() < D);
      check("out0_valid", out0_valid, h0);
      check("out1_valid", out1_valid, h1);
      if (h0) check("out0_data", out0_data, q[0].data);
      if (h1) check("out1_data", out1_data, q[0].data);
      check("out0_count", out0_count, m_cnt0);
      check("out1_count", out1_count, m_cnt1);
    end
  end

  // Called on a falling edge; returns on the falling edge after the accepting rise.
  task automatic send(input logic s, input logic [W-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (!empty && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain_empty"}, empty, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_empty",  empty,      1'b1);
    check("rst_full",   full,       1'b0);
    check("rst_ready",  in_ready,   1'b1);
    check("rst_v0",     out0_valid, 1'b0);
    check("rst_v1",     out1_valid, 1'b0);
    check("rst_d0",     out0_data,  32'h0);
    check("rst_d1",     out1_data,  32'h0);
    rst = 1'b0;

    // Single word to out0, one-cycle latency.
    out0_ready = 1'b1;
    send(SEL_OUT0, 32'h1111_1111);
    check("t1_v0",  out0_valid, 1'b1);
    check("t1_d0",  out0_data,  32'h1111_1111);
    check("t1_v1",  out1_valid, 1'b0);
    @(negedge clk);
    check("t1_cnt0", out0_count, 16'd1);

    // Alternating destinations at full rate.
    do_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(i[0], 32'hA0 + i);
    repeat (2) @(negedge clk);
    check("t2_cnt0", out0_count, 16'd2);
    check("t2_cnt1", out1_count, 16'd2);

    // Head-of-line blocking with out1 stalled.
    do_reset();
    out0_ready = 1'b1;
    out1_ready = 1'b0;
    send(SEL_OUT1, 32'hB0);
    send(SEL_OUT0, 32'hB1);
    check("t3_full",  full,       1'b1);
    check("t3_ready", in_ready,   1'b0);
    check("t3_v1",    out1_valid, 1'b1);
    check("t3_d1",    out1_data,  32'hB0);
    check("t3_v0",    out0_valid, 1'b0);
    fork
      send(SEL_OUT0, 32'hB2);
      begin
        repeat (3) @(negedge clk);
        out1_ready = 1'b1;
      end
    join
    drain("t3");
    check("t3_cnt0", out0_count, 16'd2);
    check("t3_cnt1", out1_count, 16'd1);

    // Simultaneous push/pop at occupancy 1 across pointer wraps.
    do_reset();
    out0_ready = 1'b0;
    send(SEL_OUT0, 32'hC0);
    out0_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      send(SEL_OUT0, 32'hC0 + i);
      check("t4_not_empty", empty, 1'b0);
      check("t4_not_full",  full,  1'b0);
    end
    check("t4_cnt0", out0_count, 16'd10);
    check("t4_head", out0_data,  32'hCA);
    drain("t4");

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 9) < 6);
      in_sel     = $urandom_range(0, 1);
      in_data    = $urandom;
      out0_ready = ($urandom_range(0, 9) < 7);
      out1_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drain("rand");

    // Asynchronous reset mid-cycle while full.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(SEL_OUT0, 32'hD0);
    send(SEL_OUT1, 32'hD1);
    check("t6_full", full, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_empty", empty,      1'b1);
    check("t6_full0", full,       1'b0);
    check("t6_v0",    out0_valid, 1'b0);
    check("t6_v1",    out1_valid, 1'b0);
    check("t6_cnt0",  out0_count, 16'd0);
    check("t6_cnt1",  out1_count, 16'd0);
    @(negedge clk);
    rst        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_post_v0", out0_valid, 1'b0);
    check("t6_post_v1", out1_valid, 1'b0);

    // Counter wrap on out0.
    sent  = 0;
    guard = 0;
    in_sel     = SEL_OUT0;
    out0_ready = 1'b1;
    while (sent < 65535 && guard < 70000) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      if (in_ready) sent++;
      guard++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_cnt_max", out0_count, 16'hFFFF);
    send(SEL_OUT0, 32'hE0);
    @(negedge clk);
    check("t5_cnt_wrap", out0_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
